// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped LED, switch and timer registers.
//   clock, resetn     : clock, asynchronous active-low reset
//   mem_addr          : CPU byte address (low two bits ignored, full-word access)
//   mem_datain, wmem  : store data and store strobe
//   mem_dataout       : load data, combinational from mem_addr
//   sw                : asynchronous switch inputs (two-flop synchronized)
//   led               : LED register
//   irq               : timer match flag
module dmem_mmio #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned PRESCALE  = 50
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_datain,
    input  logic        wmem,
    output logic [31:0] mem_dataout,
    input  logic [9:0]  sw,
    output logic [9:0]  led,
    output logic        irq
);
    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Word addresses (byte address >> 2) of the MMIO registers
    localparam logic [29:0] W_LED  = 30'h3FFF_FFC0;
    localparam logic [29:0] W_SW   = 30'h3FFF_FFC1;
    localparam logic [29:0] W_CNT  = 30'h3FFF_FFC2;
    localparam logic [29:0] W_CMP  = 30'h3FFF_FFC3;
    localparam logic [29:0] W_STAT = 30'h3FFF_FFC4;

    logic [31:0]    ram [RAM_WORDS];
    logic [AW-1:0]  word;
    logic           ram_sel;
    logic [9:0]     sw_meta;
    logic [9:0]     sw_sync;
    logic [PW-1:0]  pre;
    logic           tick;
    logic [31:0]    cnt;
    logic [31:0]    cmp;
    logic           wr_ram;
    logic           wr_led;
    logic           wr_cnt;
    logic           wr_cmp;
    logic           wr_clr;
    logic           match;

    // Address decode
    assign word    = mem_addr[AW+1:2];
    assign ram_sel = (mem_addr[31:AW+2] == '0);
    assign wr_ram  = wmem && ram_sel;
    assign wr_led  = wmem && (mem_addr[31:2] == W_LED);
    assign wr_cnt  = wmem && (mem_addr[31:2] == W_CNT);
    assign wr_cmp  = wmem && (mem_addr[31:2] == W_CMP);
    assign wr_clr  = wmem && (mem_addr[31:2] == W_STAT) && mem_datain[0];

    // Tick on the cycle whose edge wraps the prescaler back to 0
    assign tick  = (pre == PW'(PRESCALE - 1));
    // A CPU write to CNT on a tick cycle suppresses both the increment and the match
    assign match = tick && !wr_cnt && (cnt == cmp);

    // Zero-latency read mux; unmapped addresses read as zero
    always_comb begin
        mem_dataout = 32'd0;
        if (ram_sel) begin
            mem_dataout = ram[word];
        end else begin
            case (mem_addr[31:2])
                W_LED:   mem_dataout = 32'(led);
                W_SW:    mem_dataout = 32'(sw_sync);
                W_CNT:   mem_dataout = cnt;
                W_CMP:   mem_dataout = cmp;
                W_STAT:  mem_dataout = 32'(irq);
                default: mem_dataout = 32'd0;
            endcase
        end
    end

    // RAM has no reset; stores are blocked while resetn is low
    always_ff @(posedge clock) begin
        if (wr_ram && resetn) begin
            ram[word] <= mem_datain;
        end
    end

    // LED register and switch synchronizer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led     <= 10'd0;
            sw_meta <= 10'd0;
            sw_sync <= 10'd0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (wr_led) begin
                led <= mem_datain[9:0];
            end
        end
    end

    // Prescaler, counter, compare and match flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre <= '0;
            cnt <= 32'd0;
            cmp <= 32'hFFFF_FFFF;
            irq <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (wr_cnt) begin
                cnt <= mem_datain;
            end else if (tick) begin
                cnt <= (cnt == cmp) ? 32'd0 : cnt + 32'd1;
            end
            if (wr_cmp) begin
                cmp <= mem_datain;
            end
            // Set has priority over a simultaneous clear
            if (match) begin
                irq <= 1'b1;
            end else if (wr_clr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: driver pushes model expectations, monitor compares.
module tb_dmem_mmio;
    localparam int unsigned P = 4;
    localparam logic [31:0] A_LED  = 32'hFFFF_FF00;
    localparam logic [31:0] A_SW   = 32'hFFFF_FF04;
    localparam logic [31:0] A_CNT  = 32'hFFFF_FF08;
    localparam logic [31:0] A_CMP  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_STAT = 32'hFFFF_FF10;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_datain = 32'd0;
    logic        wmem = 1'b0;
    logic [31:0] mem_dataout;
    logic [9:0]  sw = 10'd0;
    logic [9:0]  led;
    logic        irq;

    always #5 clock = ~clock;

    dmem_mmio #(.RAM_WORDS(1024), .PRESCALE(P)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .wmem        (wmem),
        .mem_dataout (mem_dataout),
        .sw          (sw),
        .led         (led),
        .irq         (irq)
    );

    typedef struct {
        bit          chk_dout;
        logic [31:0] dout;
        logic [9:0]  led;
        logic        irq;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    logic  sample = 1'b0;
    int    n_total = 0;
    int    n_pass = 0;

    // Reference model: architectural state and clock count modulo PRESCALE
    logic [31:0] m_ram [int];
    logic [9:0]  m_led;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_flag;
    int unsigned m_phase;
    logic [9:0]  m_sw1;
    logic [9:0]  m_sw2;

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        logic [31:0] aw;
        aw = {a[31:2], 2'b00};
        known = 1'b1;
        if (aw < 32'd4096) begin
            if (m_ram.exists(int'(a[11:2]))) return m_ram[int'(a[11:2])];
            known = 1'b0;
            return 32'd0;
        end
        case (aw)
            A_LED:   return {22'd0, m_led};
            A_SW:    return {22'd0, m_sw2};
            A_CNT:   return m_cnt;
            A_CMP:   return m_cmp;
            A_STAT:  return {31'd0, m_flag};
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the model with the given access applied
    task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic we);
        logic [31:0] aw;
        bit tick;
        bit set;
        aw = {a[31:2], 2'b00};
        m_sw2 = m_sw1;
        m_sw1 = sw;
        m_phase = (m_phase + 1) % P;
        tick = (m_phase == 0);
        set = 1'b0;
        if (we && aw == A_CNT) begin
            m_cnt = d;
        end else if (tick) begin
            if (m_cnt == m_cmp) begin
                set = 1'b1;
                m_cnt = 32'd0;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (we && aw == A_CMP) m_cmp = d;
        if (set) m_flag = 1'b1;
        else if (we && aw == A_STAT && d[0]) m_flag = 1'b0;
        if (we && aw == A_LED) m_led = d[9:0];
        if (we && aw < 32'd4096) m_ram[int'(a[11:2])] = d;
    endtask

    // Drive one cycle (entered at posedge+1), push expectation, advance model
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input string tag);
        exp_t e;
        bit known;
        mem_addr = a;
        mem_datain = d;
        wmem = we;
        e.dout = m_read(a, known);
        e.chk_dout = known;
        e.led = m_led;
        e.irq = m_flag;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        sample = 1'b1;
        if (resetn) m_edge(a, d, we);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m_led = 10'd0;
        m_cnt = 32'd0;
        m_cmp = 32'hFFFF_FFFF;
        m_flag = 1'b0;
        m_phase = 0;
        m_sw1 = 10'd0;
        m_sw2 = 10'd0;
        cyc(A_CNT, 32'd0, 1'b0, "rst_cnt");
        cyc(A_CMP, 32'd0, 1'b0, "rst_cmp");
        cyc(A_LED, 32'hFFFF_FFFF, 1'b1, "rst_wmem_ignored");
        resetn = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: pops one expectation per sampled cycle
    always @(negedge clock) begin
        if (sample) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                exp_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (e.chk_dout) chk({t, ".dout"}, mem_dataout, e.dout);
                chk({t, ".led"}, {22'd0, led}, {22'd0, e.led});
                chk({t, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected finish", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic [31:0] unm [4];
        unm[0] = 32'h0000_1000;
        unm[1] = 32'hFFFF_FF14;
        unm[2] = 32'h8000_0010;
        unm[3] = 32'hFFFF_FEFC;

        @(posedge clock);
        #1;
        do_reset();

        // RAM word access, low address bits ignored, unmapped reads/writes
        cyc(32'h0000_0010, 32'h1234_5678, 1'b1, "ram_wr");
        cyc(32'h0000_0013, 32'd0, 1'b0, "ram_rd_unaligned");
        cyc(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, "unmapped_wr");
        cyc(32'h0000_1000, 32'd0, 1'b0, "unmapped_rd");
        cyc(32'h0000_0010, 32'hAAAA_5555, 1'b1, "ram_read_during_write");
        cyc(32'h0000_0010, 32'd0, 1'b0, "ram_new_value");

        // LED and switch synchronizer
        cyc(A_LED, 32'hFFFF_FFFF, 1'b1, "led_wr");
        cyc(A_LED, 32'd0, 1'b0, "led_rd");
        sw = 10'h155;
        cyc(A_SW, 32'd0, 1'b0, "sw_edge0");
        cyc(A_SW, 32'd0, 1'b1, "sw_edge1_wr_ignored");
        cyc(A_SW, 32'd0, 1'b0, "sw_edge2");

        // Timer match with PRESCALE=4, CMP=3
        do_reset();
        cyc(A_CMP, 32'd3, 1'b1, "cmp_wr");
        for (int i = 0; i < 18; i++) cyc(A_CNT, 32'd0, 1'b0, "cnt_run");
        cyc(A_STAT, 32'd1, 1'b1, "stat_clr");
        cyc(A_STAT, 32'd0, 1'b0, "stat_after_clr");

        // Counter wrap from all ones
        cyc(A_CMP, 32'd5, 1'b1, "cmp5");
        cyc(A_CNT, 32'hFFFF_FFFF, 1'b1, "cnt_max");
        for (int i = 0; i < 5; i++) cyc(A_CNT, 32'd0, 1'b0, "cnt_wrap");

        // CNT write coinciding with a tick, then clear coinciding with a match
        cyc(A_CMP, 32'h12, 1'b1, "cmp12");
        for (int i = 0; i < 8 && m_phase != P - 1; i++) cyc(A_CNT, 32'd0, 1'b0, "align_tick");
        cyc(A_CNT, 32'h10, 1'b1, "cnt_wr_on_tick");
        cyc(A_CNT, 32'd0, 1'b0, "cnt_after_tick_wr");
        for (int i = 0; i < 40 && !(m_phase == P - 1 && m_cnt == m_cmp); i++)
            cyc(A_CNT, 32'd0, 1'b0, "wait_match");
        cyc(A_STAT, 32'd1, 1'b1, "clr_on_match");
        cyc(A_STAT, 32'd0, 1'b0, "flag_kept");
        cyc(A_CNT, 32'd0, 1'b0, "cnt_after_match");

        // Reset mid-count with flag set and LEDs lit; RAM survives
        cyc(A_LED, 32'h0F, 1'b1, "led_0f");
        cyc(A_CNT, 32'd0, 1'b0, "pre_reset");
        do_reset();
        cyc(32'h0000_0010, 32'd0, 1'b0, "ram_kept");
        cyc(32'h0000_0011, 32'd0, 1'b0, "ram_kept_unaligned");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            d = $urandom;
            we = 1'($urandom_range(0, 1));
            case (r)
                0, 1, 2: a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
                3:       a = A_LED;
                4:       a = A_SW;
                5: begin a = A_CNT; d = 32'($urandom_range(0, 12)); end
                6: begin a = A_CMP; d = 32'($urandom_range(0, 12)); end
                7:       a = A_STAT;
                8:       a = unm[$urandom_range(0, 3)];
                default: a = 32'h0000_0FFC + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            else cyc(a, d, we, "rand");
        end

        wmem = 1'b0;
        sample = 1'b0;
        @(negedge clock);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, giving the number of 32-bit RAM words (power of two, at most 1024).
REQ-002 SHALL have parameter PRESCALE, default 50, giving the number of clocks per timer tick (at least 1).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_addr, input, 32 bits: CPU data byte address.
REQ-006 SHALL have port mem_datain, input, 32 bits: CPU store data.
REQ-007 SHALL have port wmem, input, 1 bit: store strobe, one write per cycle while high.
REQ-008 SHALL have port mem_dataout, output, 32 bits: load data, combinational from mem_addr.
REQ-009 SHALL have port sw, input, 10 bits: asynchronous switch inputs.
REQ-010 SHALL have port led, output, 10 bits: LED register.
REQ-011 SHALL have port irq, output, 1 bit: timer match flag.

Function
REQ-012 SHALL ignore mem_addr[1:0]; all accesses are full-word.
REQ-013 SHALL decode the following map:
- RAM: 0x0000_0000 to 4*RAM_WORDS-1, word index mem_addr[11:2].
- LED: 0xFFFF_FF00, RW, bits [9:0].
- SW: 0xFFFF_FF04, RO.
- CNT: 0xFFFF_FF08, RW.
- CMP: 0xFFFF_FF0C, RW.
- STAT: 0xFFFF_FF10, bit0 = match flag.
REQ-014 SHALL return 0 on reads of any unmapped address and SHALL ignore writes to any unmapped address.
REQ-015 SHALL drive mem_dataout in the same cycle mem_addr is presented, with zero-cycle read latency.
REQ-016 SHALL perform a RAM or register write at the rising edge when wmem=1; a read of the same address in the same cycle SHALL return the old value.
REQ-017 SHALL zero-extend LED and SW reads to 32 bits; writes to LED SHALL store mem_datain[9:0].
REQ-018 SHALL pass sw through a two-flop synchronizer, so the SW read reflects a sw change 2 clocks later.
REQ-019 SHALL ignore writes to SW.
REQ-020 SHALL run a prescaler counting 0..PRESCALE-1 and asserting a tick when it wraps to 0.
REQ-021 SHALL, on each tick: if CNT==CMP, set flag and load CNT=0; otherwise increment CNT, wrapping 0xFFFF_FFFF to 0.
REQ-022 SHALL, when a CPU write to CNT coincides with a tick, load mem_datain into CNT (CPU wins) and SHALL NOT set flag that cycle.
REQ-023 SHALL not reset the prescaler on a CNT write.
REQ-024 SHALL treat a CMP write as taking effect from the next tick.
REQ-025 SHALL clear flag on a STAT write with mem_datain[0]=1, and SHALL ignore STAT writes with mem_datain[0]=0.
REQ-026 SHALL, when a match and a clear occur in the same cycle, leave flag=1 (set wins).
REQ-027 SHALL drive irq = flag, registered.

Reset
REQ-028 SHALL, while resetn=0, asynchronously force:
- led=0, CNT=0, CMP=0xFFFF_FFFF, flag=0, irq=0;
- prescaler=0, synchronizer flops=0.
REQ-029 SHALL not reset RAM contents, which are undefined until written.
REQ-030 SHALL ignore wmem while resetn=0.
REQ-031 SHALL, on reset mid-count, restart the timer from 0 on the first clock after resetn rises.

Verification
REQ-032 SHALL be covered by: write 0x1234_5678 to 0x0000_0010, then read 0x0000_0013 -> 0x1234_5678; read 0x0000_1000 -> 0.
REQ-033 SHALL be covered by: write 0xFFFF_FFFF to LED -> led=0x3FF, read LED=0x0000_03FF; set sw=0x155 -> SW read =0x155 no earlier than the 2nd edge.
REQ-034 SHALL be covered by: PRESCALE=4, CMP=3, CNT=0 -> irq rises after 16 clocks and CNT reads 0; write STAT=1 -> irq=0 next cycle.
REQ-035 SHALL be covered by: a CNT write of 0x10 on a tick cycle -> CNT=0x10, no increment; a STAT clear on a match cycle -> irq stays 1.
REQ-036 SHALL be covered by: resetn pulsed low mid-count with flag=1 and led=0x0F -> led=0, irq=0, CNT=0, CMP=0xFFFF_FFFF immediately; RAM word written before reset still reads back.
